// File: rtl/sdram_porta_scheduler.sv
// sdram_porta_scheduler: arbitrates SDRAM port A between the game loader and
// the NES CPU. While loading, loader bytes are queued in a small FIFO and
// written out one per NES memory slot; once loading is done and the queue has
// drained, port A is handed straight through to the CPU.
module sdram_porta_scheduler #(
  parameter int         ADDR_W     = 22,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [1:0] SLOT       = 2'd3
) (
  input  logic                        clock,
  input  logic                        R_reset,
  input  logic [1:0]                  nes_ce,
  input  logic                        load_done,
  input  logic                        ld_valid,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [7:0]                  ld_data,
  output logic                        ld_ready,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic                        cpu_read,
  input  logic                        cpu_write,
  input  logic [7:0]                  cpu_dout,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic                        mem_oe,
  output logic [7:0]                  mem_din,
  output logic                        mode_load,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [7:0]        fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        din_r;
  logic              overflow_r;

  logic slot_s;
  logic empty_s;
  logic full_s;
  logic loader_s;
  logic run_s;
  logic push_s;
  logic pop_s;
  logic drop_s;
  logic reload_s;

  assign slot_s   = (nes_ce == SLOT);
  assign empty_s  = (count_r == {CNT_W{1'b0}});
  assign full_s   = (count_r == CNT_W'(FIFO_DEPTH));
  assign run_s    = (state_r == ST_RUN);
  assign loader_s = (state_r == ST_LOAD) || (state_r == ST_DRAIN);
  // Acceptance looks only at the registered count, never at a same-cycle pop.
  assign push_s   = (state_r == ST_LOAD) && ld_valid && !full_s;
  assign drop_s   = (state_r == ST_LOAD) && ld_valid && full_s;
  assign pop_s    = loader_s && slot_s && !empty_s;
  assign reload_s = run_s && !load_done;

  // State register.
  always_ff @(posedge clock) begin
    if (R_reset) state_r <= ST_LOAD;
    else         state_r <= state_next_s;
  end

  // Next-state logic: load_done is a level sampled every clock.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (load_done) state_next_s = ST_DRAIN;
        else           state_next_s = ST_LOAD;
      end
      ST_DRAIN: begin
        if (slot_s && empty_s) state_next_s = ST_RUN;
        else                   state_next_s = ST_DRAIN;
      end
      ST_RUN: begin
        if (!load_done) state_next_s = ST_LOAD;
        else            state_next_s = ST_RUN;
      end
      default: state_next_s = ST_LOAD;
    endcase
  end

  // FIFO storage: written at the tail on every accepted loader byte.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= ld_addr;
      fifo_data_r[wr_ptr_r] <= ld_data;
    end
  end

  // FIFO pointers and occupancy; pointers restart on a game reload.
  always_ff @(posedge clock) begin
    if (R_reset || reload_s) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Write issue: once per slot, launch the FIFO head or an idle slot.
  // Address and data hold through idle slots and while the CPU owns the port.
  always_ff @(posedge clock) begin
    if (R_reset) begin
      we_r   <= 1'b0;
      addr_r <= {ADDR_W{1'b0}};
      din_r  <= 8'd0;
    end else if (loader_s && slot_s) begin
      we_r <= !empty_s;
      if (!empty_s) begin
        addr_r <= fifo_addr_r[rd_ptr_r];
        din_r  <= fifo_data_r[rd_ptr_r];
      end
    end
  end

  // Sticky overflow: a loader byte arrived while the FIFO was full.
  always_ff @(posedge clock) begin
    if (R_reset)     overflow_r <= 1'b0;
    else if (drop_s) overflow_r <= 1'b1;
  end

  assign mem_addr   = run_s ? cpu_addr  : addr_r;
  assign mem_we     = run_s ? cpu_write : we_r;
  assign mem_oe     = run_s ? cpu_read  : 1'b0;
  assign mem_din    = run_s ? cpu_dout  : din_r;
  assign mode_load  = !run_s;
  assign ld_ready   = (state_r == ST_LOAD) && !full_s;
  assign fifo_level = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_sdram_porta_scheduler.sv
// Testbench for sdram_porta_scheduler: a directed vector table, hand-written
// corner-case sequences and a randomized run, all checked every clock against
// a queue-based reference model.
module tb_sdram_porta_scheduler;

  localparam int ADDR_W = 22;
  localparam int DEPTH  = 8;

  logic              clock = 1'b0;
  logic              R_reset;
  logic [1:0]        nes_ce;
  logic              load_done;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_read;
  logic              cpu_write;
  logic [7:0]        cpu_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_oe;
  logic [7:0]        mem_din;
  logic              mode_load;
  logic [3:0]        fifo_level;
  logic              overflow;

  always #5 clock = ~clock;

  sdram_porta_scheduler #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .SLOT(2'd3)) dut (
    .clock(clock), .R_reset(R_reset), .nes_ce(nes_ce), .load_done(load_done),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_dout(cpu_dout),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe), .mem_din(mem_din),
    .mode_load(mode_load), .fifo_level(fifo_level), .overflow(overflow)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = loader filling, 1 = loader finishing, 2 = CPU owns port.
  int          m_mode;
  logic [29:0] q[$];
  logic        m_we;
  logic [21:0] m_addr;
  logic [7:0]  m_din;
  logic        m_ovf;

  task automatic model_edge();
    int          md;
    int          n;
    logic [29:0] h;
    bit          slot;
    slot = (nes_ce == 2'd3);
    if (R_reset) begin
      m_mode = 0; q.delete(); m_we = 1'b0; m_addr = 22'd0; m_din = 8'd0; m_ovf = 1'b0;
    end else begin
      md = m_mode;
      n  = q.size();
      if (md != 2 && slot) begin
        m_we = (n != 0);
        if (n != 0) begin
          h = q.pop_front();
          m_addr = h[29:8];
          m_din  = h[7:0];
        end
      end
      if (md == 0 && ld_valid) begin
        if (n < DEPTH) q.push_back({ld_addr, ld_data});
        else           m_ovf = 1'b1;
      end
      if (md == 0 && load_done)           m_mode = 1;
      if (md == 1 && slot && n == 0)      m_mode = 2;
      if (md == 2 && !load_done)          m_mode = 0;
    end
  endtask

  task automatic check_all();
    bit run;
    run = (m_mode == 2);
    chk("mem_we",     32'(run ? cpu_write : m_we),   32'(mem_we));
    chk("mem_oe",     32'(mem_oe),                   32'(run ? cpu_read : 1'b0));
    chk("mem_addr",   32'(mem_addr),                 32'(run ? cpu_addr : m_addr));
    chk("mem_din",    32'(mem_din),                  32'(run ? cpu_dout : m_din));
    chk("mode_load",  32'(mode_load),                32'(!run));
    chk("ld_ready",   32'(ld_ready),                 32'(m_mode == 0 && q.size() < DEPTH));
    chk("fifo_level", 32'(fifo_level),               32'(q.size()));
    chk("overflow",   32'(overflow),                 32'(m_ovf));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
    nes_ce = nes_ce + 2'd1;
  endtask

  // Issue tracker: after each slot edge, a write must carry the next expected address.
  logic [21:0] trk_base;
  int          trk_k;

  task automatic step_track();
    step();
    if (nes_ce == 2'd0 && mem_we) begin
      chk("issue_order", 32'(mem_addr), 32'(trk_base + 22'(trk_k)));
      trk_k++;
    end
  endtask

  typedef struct {
    logic        vld;
    logic [21:0] a;
    logic [7:0]  d;
    logic        we;
    logic [21:0] ea;
    logic [7:0]  ed;
    logic [3:0]  lvl;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Push coinciding with SLOT (row 0); issued at the next SLOT for 4 clocks.
    tbl[0] = '{1'b1, 22'h000010, 8'hA5, 1'b0, 22'h0, 8'h00, 4'd1};
    tbl[1] = '{1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 8'h00, 4'd1};
    tbl[2] = '{1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 8'h00, 4'd1};
    tbl[3] = '{1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 8'h00, 4'd1};
    tbl[4] = '{1'b0, 22'h0, 8'h00, 1'b1, 22'h000010, 8'hA5, 4'd0};
    tbl[5] = '{1'b0, 22'h0, 8'h00, 1'b1, 22'h000010, 8'hA5, 4'd0};
    tbl[6] = '{1'b0, 22'h0, 8'h00, 1'b1, 22'h000010, 8'hA5, 4'd0};
    tbl[7] = '{1'b0, 22'h0, 8'h00, 1'b1, 22'h000010, 8'hA5, 4'd0};
    tbl[8] = '{1'b0, 22'h0, 8'h00, 1'b0, 22'h000010, 8'hA5, 4'd0};

    nes_ce = 2'd0; R_reset = 1'b1; load_done = 1'b0; ld_valid = 1'b0;
    ld_addr = 22'd0; ld_data = 8'd0; cpu_addr = 22'd0; cpu_read = 1'b0;
    cpu_write = 1'b0; cpu_dout = 8'd0;
    m_mode = 0; m_we = 1'b0; m_addr = 22'd0; m_din = 8'd0; m_ovf = 1'b0;
    trk_base = 22'd0; trk_k = 0;

    // Reset check
    step(); step();
    chk("rst_ld_ready",  32'(ld_ready),   32'd1);
    chk("rst_mode_load", 32'(mode_load),  32'd1);
    chk("rst_level",     32'(fifo_level), 32'd0);
    chk("rst_we",        32'(mem_we),     32'd0);
    chk("rst_addr",      32'(mem_addr),   32'd0);
    R_reset = 1'b0;

    // Vector table, starting on a SLOT clock
    for (int n = 0; n < 4 && nes_ce != 2'd3; n++) step();
    for (int i = 0; i < 9; i++) begin
      ld_valid = tbl[i].vld; ld_addr = tbl[i].a; ld_data = tbl[i].d;
      step();
      chk("tbl_we",    32'(mem_we),     32'(tbl[i].we));
      chk("tbl_addr",  32'(mem_addr),   32'(tbl[i].ea));
      chk("tbl_din",   32'(mem_din),    32'(tbl[i].ed));
      chk("tbl_level", 32'(fifo_level), 32'(tbl[i].lvl));
    end

    // Overflow: 12 back-to-back pushes starting at nes_ce==0
    trk_base = 22'h000100; trk_k = 0;
    for (int i = 0; i < 12; i++) begin
      ld_valid = 1'b1; ld_addr = 22'h000100 + 22'(i); ld_data = 8'(i);
      step_track();
      if (i == 9) begin
        chk("ovf_full_level", 32'(fifo_level), 32'd8);
        chk("ovf_ready_low",  32'(ld_ready),   32'd0);
      end
    end
    ld_valid = 1'b0;
    chk("ovf_sticky", 32'(overflow), 32'd1);
    for (int i = 0; i < 40; i++) step_track();
    chk("ovf_issue_count", 32'(trk_k), 32'd10);
    chk("ovf_empty", 32'(fifo_level), 32'd0);

    // Drain: 3 pending, then load_done; expect 3 writes, then RUN
    trk_base = 22'h000200; trk_k = 0;
    for (int n = 0; n < 4 && nes_ce != 2'd0; n++) step();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_addr = 22'h000200 + 22'(i); ld_data = 8'h20 + 8'(i);
      step_track();
    end
    ld_valid = 1'b0; load_done = 1'b1;
    step_track();
    for (int n = 0; n < 20 && mode_load; n++) step_track();
    chk("drain_to_run", 32'(mode_load), 32'd0);
    chk("drain_issues", 32'(trk_k), 32'd3);
    cpu_write = 1'b1; cpu_addr = 22'h001234; cpu_dout = 8'h5A;
    step();
    chk("run_we",  32'(mem_we),  32'd1);
    chk("run_din", 32'(mem_din), 32'h5A);

    // RUN passthrough, then reload
    cpu_write = 1'b0; cpu_read = 1'b1; cpu_addr = 22'h008000;
    step();
    chk("run_oe",   32'(mem_oe),   32'd1);
    chk("run_addr", 32'(mem_addr), 32'h008000);
    load_done = 1'b0;
    step();
    chk("reload_mode",  32'(mode_load), 32'd1);
    chk("reload_oe",    32'(mem_oe),    32'd0);
    chk("reload_ready", 32'(ld_ready),  32'd1);
    cpu_read = 1'b0;

    // Reset mid-load: two fillers absorb the slot pops, 5 markers stay pending
    for (int n = 0; n < 4 && nes_ce != 2'd1; n++) step();
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_addr  = (i < 2) ? 22'h000300 + 22'(i) : 22'h3F0000 + 22'(i);
      ld_data  = 8'(i);
      step();
    end
    ld_valid = 1'b0;
    chk("mid_pending", 32'(fifo_level), 32'd5);
    R_reset = 1'b1;
    step();
    chk("mid_level", 32'(fifo_level), 32'd0);
    chk("mid_we",    32'(mem_we),     32'd0);
    R_reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("mid_discard", 32'(mem_we && mem_addr[21:16] == 6'h3F), 32'd0);
    end

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      R_reset   = ($urandom_range(299) == 0);
      if ($urandom_range(39) == 0) load_done = ~load_done;
      ld_valid  = ($urandom_range(2) != 0);
      ld_addr   = 22'($urandom);
      ld_data   = 8'($urandom);
      cpu_addr  = 22'($urandom);
      cpu_read  = 1'($urandom);
      cpu_write = 1'($urandom);
      cpu_dout  = 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
